div_seq_param: RTL
==================

// Module: div_seq_param
// PURPOSE
//  Parametrised sequential restoring divider: 2W-bit dividend / W-bit divisor -> W-bit quotient + remainder.
//  Successor to the fixed 32/16 divider. Adds:
//   - a generic width W;
//   - a per-operation signed/unsigned mode;
//   - early overflow exit;
//   - an optional divide-by-zero flag.
//  Sits beside the PDP-11 EU as the DIV engine. One quotient bit is produced per clock.
// PARAMETERS
//  WIDTH  16  divisor/quotient/remainder width W; dividend is 2W. Legal range 4..64.
// PORTS
//  clk        in   1     system clock, rising edge
//  reset      in   1     asynchronous, active-low reset (0 = reset)
//  ready      in   1     start request, level; sampled only in IDLE
//  signed_op  in   1     1 = two's-complement operands, 0 = unsigned; sampled with ready
//  dividend   in   2W    dividend; sampled with ready
//  divider    in   W     divisor; sampled with ready
//  done       out  1     result valid; held until ready is seen low
//  quotient   out  W     quotient
//  remainder  out  W     remainder
//  overflow   out  1     quotient unrepresentable or divisor zero
//  divzero    out  1     divisor zero (only with DIV_DBZ_FLAG_EN)
// BEHAVIOUR
//  Reset (reset=0, asynchronous):
//   - state = IDLE; done, quotient, remainder, overflow, divzero all = 0.
//   - Reset during RUN/FIX aborts the operation; no partial result is kept.
//  State machine: IDLE -> RUN -> FIX -> DONE -> IDLE.
//  IDLE:
//   - On an edge with ready=1, latch operands and mode.
//   - In signed mode, convert dividend and divisor to magnitudes; keep sign_q = sd^sv and sign_r = sd.
//   - Set bitnum = W-1.
//   - Early check (magnitudes): divisor==0, or high W bits of the dividend >= divisor -> DONE, overflow=1.
//   - Otherwise -> RUN.
//  RUN (W cycles, one per edge):
//   - Shift partial remainder (W+1 bits) left by 1, bringing in the next dividend bit.
//   - Trial-subtract the divisor. If non-negative, keep the difference and set quotient bit = 1; else bit = 0.
//   - bitnum decrements; after the bitnum==0 edge -> FIX.
//   - ready is ignored while in RUN.
//  FIX (1 cycle):
//   - Signed mode: negate quotient if sign_q; negate remainder if sign_r.
//   - Signed range check on the magnitude result:
//     - overflow=1 if the magnitude exceeds 2^(W-1)-1 when sign_q=0;
//     - overflow=1 if the magnitude exceeds 2^(W-1) when sign_q=1.
//   - Unsigned mode: passes through unchanged.
//   - -> DONE.
//  DONE:
//   - done=1; outputs are stable.
//   - If ready=0 on an edge -> IDLE, and done drops on that edge. Outputs keep their values until the next start.
//  Overflow: quotient and remainder are forced to 0.
//  Remainder sign rule: the remainder always takes the dividend's sign (truncating division), PDP-11 semantics.
//  Latency, with the start seen at edge N:
//   - normal: done=1 after edge N+W+2;
//   - early overflow: done=1 after edge N+1.
//  Back-to-back: a new start needs ready low for at least one edge while in DONE.
//   - ready held high across DONE does not restart; done stays high.
// CONFIGURATION
//  DIV_DBZ_FLAG_EN defined:
//   - divzero port exists; set with overflow when the divisor is 0; cleared on the next start and on reset.
//  DIV_DBZ_FLAG_EN undefined:
//   - divzero port is absent; a zero divisor is reported only as overflow=1. Same latency.
// TESTING (WIDTH=16)
//  1. unsigned: dividend=10, divider=3
//     -> q=3, r=1, ov=0; done high 18 edges after the start edge.
//  2. signed: 0x7FFFFFFF / 2
//     -> early ov=1, q=0, r=0, done after 1 edge. Same operands, unsigned -> also ov=1.
//  3. signed:
//     - 0xFFFFFFF9 / 2 -> q=0xFFFD, r=0xFFFF, ov=0.
//     - 0x00000002 / 0xFFFE -> q=0xFFFF, r=0.
//  4. signed range boundary:
//     - 0xFFFF8000 / 1 -> q=0x8000, ov=0.
//     - 0x00008000 / 1 -> ov=1 (caught in FIX).
//  5. divider=0, any dividend -> ov=1 (divzero=1 with DIV_DBZ_FLAG_EN), done after 1 edge; then a valid op -> divzero=0.
//  6. reset=0 pulsed mid-RUN (bitnum=7) -> all outputs 0, IDLE.
//     - Next start 0x0001_0000 / 0x0100 -> q=0x0100, r=0.
//     - ready held high through DONE causes no restart.

Source files
------------

// File: rtl/div_seq_param.sv
// Sequential restoring divider: 2W-bit dividend / W-bit divisor, signed or unsigned, one quotient bit per clock.
// Define DIV_DBZ_FLAG_EN to add the divzero output flag.
module div_seq_param #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ready,
    input  logic                 signed_op,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divider,
    output logic                 done,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic                 overflow
`ifdef DIV_DBZ_FLAG_EN
    ,
    output logic                 divzero
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] MIN_MAG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]         state;
    logic [BW-1:0]      bitnum;
    logic [WIDTH:0]     part;
    logic [WIDTH-1:0]   work;
    logic [WIDTH-1:0]   dvs;
    logic               mode;
    logic               sign_q;
    logic               sign_r;

    logic               dd_neg;
    logic               dv_neg;
    logic [2*WIDTH-1:0] dd_mag;
    logic [WIDTH-1:0]   dv_mag;
    logic               early_ov;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;
    logic               fix_ov;

    always_comb begin
        dd_neg   = signed_op & dividend[2*WIDTH-1];
        dv_neg   = signed_op & divider[WIDTH-1];
        dd_mag   = dd_neg ? (~dividend + 1'b1) : dividend;
        dv_mag   = dv_neg ? (~divider + 1'b1) : divider;
        // A high half at or above the divisor means the quotient cannot fit in W bits.
        early_ov = (dv_mag == '0) || (dd_mag[2*WIDTH-1:WIDTH] >= dv_mag);
        // work holds the unconsumed dividend bits on top and grows quotient bits from the bottom.
        shifted  = {part[WIDTH-1:0], work[WIDTH-1]};
        trial    = shifted - {1'b0, dvs};
        fix_ov   = mode && (sign_q ? (work > MIN_MAG) : work[WIDTH-1]);
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            bitnum    <= '0;
            part      <= '0;
            work      <= '0;
            dvs       <= '0;
            mode      <= 1'b0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            overflow  <= 1'b0;
`ifdef DIV_DBZ_FLAG_EN
            divzero   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (ready) begin
                        mode   <= signed_op;
                        sign_q <= dd_neg ^ dv_neg;
                        sign_r <= dd_neg;
                        dvs    <= dv_mag;
                        part   <= {1'b0, dd_mag[2*WIDTH-1:WIDTH]};
                        work   <= dd_mag[WIDTH-1:0];
                        bitnum <= BW'(WIDTH-1);
`ifdef DIV_DBZ_FLAG_EN
                        divzero <= (dv_mag == '0);
`endif
                        if (early_ov) begin
                            overflow  <= 1'b1;
                            quotient  <= '0;
                            remainder <= '0;
                            state     <= S_DONE;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    part   <= trial[WIDTH] ? shifted : trial;
                    work   <= {work[WIDTH-2:0], ~trial[WIDTH]};
                    bitnum <= bitnum - 1'b1;
                    if (bitnum == '0) state <= S_FIX;
                end
                S_FIX: begin
                    if (fix_ov) begin
                        overflow  <= 1'b1;
                        quotient  <= '0;
                        remainder <= '0;
                    end else begin
                        overflow  <= 1'b0;
                        quotient  <= sign_q ? (~work + 1'b1) : work;
                        remainder <= sign_r ? (~part[WIDTH-1:0] + 1'b1) : part[WIDTH-1:0];
                    end
                    state <= S_DONE;
                end
                default: begin
                    // The first edge in DONE raises done; later edges wait for ready to drop.
                    if (!done) begin
                        done <= 1'b1;
                    end else if (!ready) begin
                        done  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
